// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the IFU, LSU and memory-port signals of mem_arbiter.
// Parameters: ADDR_W address width, DATA_W data width (DATA_W/8 byte strobes).
// Signals:
//   ifu_*  IFU read request (reqValid, addr) and response (respValid, rdata, err)
//   lsu_*  LSU request (reqValid, wen, addr, wdata, wmask) and response (respValid, rdata, err)
//   mem_*  memory request (reqValid, wen, addr, wdata, wmask) and response (respValid, rdata)
// Modports: master = arbiter view, slave = requesters and memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                ifu_reqValid;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                ifu_respValid;
    logic [DATA_W-1:0]   ifu_rdata;
    logic                ifu_err;
    logic                lsu_reqValid;
    logic                lsu_wen;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_respValid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                lsu_err;
    logic                mem_reqValid;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_respValid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata, ifu_err,
        input  lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata, lsu_err,
        output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_respValid, mem_rdata
    );

    modport slave (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata, ifu_err,
        output lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata, lsu_err,
        input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_respValid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one non-pipelined memory port between IFU and LSU with round-robin ties and a per-transaction timeout.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_arbiter_if.master: IFU/LSU requests and responses, memory request and response
// Parameters: ADDR_W, DATA_W widths; TIMEOUT max cycles per transaction (0 disables).
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic           clock,
    input logic           reset,
    mem_arbiter_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_IFU, ARB_LSU} state_t;

    state_t              state, next;
    logic                last_lsu;
    logic [CW-1:0]       cnt;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic                grant_lsu, grant_ifu, to_hit, done;

    // LSU wins a tie unless it was the last one served
    assign grant_lsu = state == ARB_IDLE && bus.lsu_reqValid && (!bus.ifu_reqValid || !last_lsu);
    assign grant_ifu = state == ARB_IDLE && bus.ifu_reqValid && !grant_lsu;
    assign to_hit    = TIMEOUT != 0 && cnt == LAST;
    assign done      = bus.mem_respValid || to_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = (state == ARB_IDLE) ? (grant_lsu ? ARB_LSU : grant_ifu ? ARB_IFU : ARB_IDLE)
             : done ? ARB_IDLE : state;
    end

    // A real response beats a timeout landing in the same cycle
    always_comb begin
        bus.mem_reqValid  = state != ARB_IDLE;
        bus.ifu_respValid = state == ARB_IFU && done;
        bus.ifu_err       = state == ARB_IFU && to_hit && !bus.mem_respValid;
        bus.ifu_rdata     = (state == ARB_IFU && bus.mem_respValid) ? bus.mem_rdata : '0;
        bus.lsu_respValid = state == ARB_LSU && done;
        bus.lsu_err       = state == ARB_LSU && to_hit && !bus.mem_respValid;
        bus.lsu_rdata     = (state == ARB_LSU && bus.mem_respValid) ? bus.mem_rdata : '0;
    end

    // Request fields are captured once at grant; later input changes are ignored
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu <= 1'b0;
            cnt      <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else if (grant_lsu || grant_ifu) begin
            last_lsu <= grant_lsu;
            cnt      <= '0;
            wen_q    <= grant_lsu && bus.lsu_wen;
            addr_q   <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wdata_q  <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q  <= grant_lsu ? bus.lsu_wmask : '0;
        end else if (state != ARB_IDLE) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Requests run one at a time (non-pipelined). Simultaneous requests are granted round-robin. A per-transaction timeout guards against a hung slave. Sits between IFU/LSU and the memory/bus bridge and produces the lsu_respValid / lsu_rdata consumed by the execute stage.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; DATA_W/8 byte-strobe lanes
TIMEOUT, 255, max cycles a granted transaction waits for mem_respValid; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ifu_reqValid  in  1  IFU read request; held until ifu_respValid
ifu_addr  in  ADDR_W  IFU fetch address
ifu_respValid  out  1  one-cycle pulse: IFU transaction complete
ifu_rdata  out  DATA_W  fetch data; valid with ifu_respValid
ifu_err  out  1  timeout flag; valid with ifu_respValid
lsu_reqValid  in  1  LSU request; held until lsu_respValid
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte strobes for stores
lsu_respValid  out  1  one-cycle pulse: LSU transaction complete
lsu_rdata  out  DATA_W  load data; valid with lsu_respValid
lsu_err  out  1  timeout flag; valid with lsu_respValid
mem_reqValid  out  1  request to memory; held for the whole transaction
mem_wen  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered byte strobes; 0 for IFU reads
mem_respValid  in  1  memory completion pulse
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: ARB_IDLE, ARB_IFU, ARB_LSU.
- Reset (reset low, asynchronous):
  - state = ARB_IDLE, last_grant = IFU, timeout counter = 0.
  - mem_* registers = 0.
  - All outputs 0.
- ARB_IDLE:
  - Only lsu_reqValid: next state ARB_LSU.
  - Only ifu_reqValid: next state ARB_IFU.
  - Both: grant the requester that is not last_grant. After reset the LSU therefore wins the first tie.
  - On grant: latch addr/wen/wdata/wmask into the mem_* registers (IFU forces wen = 0, wmask = 0), update last_grant, clear the counter.
  - No request: remain in ARB_IDLE.
- mem_reqValid = 1 exactly while in ARB_IFU or ARB_LSU.
  - Minimum latency: request sampled at cycle N, mem_reqValid high at N+1.
- In ARB_x, when mem_respValid = 1:
  - x_respValid = 1 in that same cycle.
  - x_rdata = mem_rdata passed through combinationally; x_err = 0.
  - Next state ARB_IDLE.
- In ARB_x with TIMEOUT != 0:
  - The counter increments each cycle without mem_respValid.
  - When the counter equals TIMEOUT-1 and mem_respValid = 0: x_respValid = 1, x_err = 1, x_rdata = 0, next state ARB_IDLE.
  - A transaction therefore lasts at most TIMEOUT cycles.
  - If mem_respValid and the timeout occur in the same cycle, the response wins (err = 0).
  - Counter width is clog2(TIMEOUT+1).
- The non-granted requester sees respValid = 0 and rdata = 0, and stays pending.
- Requesters must drop reqValid in the cycle after their respValid. If reqValid is still high in ARB_IDLE, it is a new request.
- There is always one ARB_IDLE cycle between transactions. With both requesters continuously active, grants alternate strictly LSU, IFU, LSU, ...
- Stray mem_respValid in ARB_IDLE (late response after a timeout or after reset) is ignored; no respValid is generated.
- Request inputs are sampled only in ARB_IDLE. Changes to addr/wdata during ARB_x have no effect.
- Reset asserted mid-transaction: immediate return to ARB_IDLE, mem_reqValid = 0, no response pulse is issued.

Test Plan:
- Single IFU read: ifu_reqValid with ifu_addr=0x80000000; mem responds 3 cycles after mem_reqValid with 0x00100093 -> mem_addr=0x80000000, mem_wen=0, mem_wmask=0; ifu_respValid for one cycle with ifu_rdata=0x00100093, ifu_err=0; FSM back to ARB_IDLE.
- LSU store: lsu_wen=1, lsu_addr=0x80001004, lsu_wdata=0xDEADBEEF, lsu_wmask=0b0011; mem responds same cycle -> mem_* carry exactly these values; lsu_respValid one cycle after the request was sampled.
- Tie after reset: both reqValid high in the same cycle -> LSU granted first, then IFU. Keep both continuously high -> grant order LSU, IFU, LSU, IFU.
- Timeout: TIMEOUT=4, never assert mem_respValid -> lsu_respValid with lsu_err=1 and lsu_rdata=0 on the 4th mem_reqValid cycle. A later stray mem_respValid in ARB_IDLE produces no response.
- Response coincides with timeout cycle: mem_respValid on the TIMEOUT-th cycle with rdata 0x12345678 -> respValid, err=0, rdata=0x12345678.
- Reset mid-transaction: drive reset low during ARB_IFU -> all outputs 0 asynchronously. After release, an LSU request is granted normally and the old IFU transaction gets no response.
